// File: rtl/pattern_player.sv
// Pattern player: steps through a synchronous ROM at a prescaled rate and
// registers each word onto the pattern output. Define PATTERN_PLAYER_PINGPONG_EN
// to make the address bounce 0..LENGTH-1..0 instead of wrapping.
module pattern_player #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 8,
  parameter int LENGTH     = 16,
  parameter int TICK_DIV   = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [1:0]            speed,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] pattern,
  output logic                  frame_start
);

  // Wide enough for the slowest step period, TICK_DIV << 3.
  localparam int CNT_W = $clog2(TICK_DIV * 8 + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LENGTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, LOAD} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        limit;
  logic                    tick;
  logic [ADDR_WIDTH-1:0]   next_addr;

  // The compare uses >= so a speed drop below the current count ticks at once.
  always_comb begin
    limit = CNT_W'(TICK_DIV) << speed;
    tick  = run && (count >= limit - 1'b1);
  end

  // NOTE: sequential state is always written with <=, so every flop samples
  // the pre-edge values and the order of statements cannot create races.
  always_ff @(posedge clk) begin
    if (rst || !run || tick) count <= '0;
    else                     count <= count + 1'b1;
  end

`ifdef PATTERN_PLAYER_PINGPONG_EN
  logic dir_down;
  logic next_dir;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_addr = '0;
    next_dir  = dir_down;
    if (LENGTH > 1) begin
      if (!dir_down) begin
        if (rom_addr == LAST) begin
          next_addr = rom_addr - 1'b1;
          next_dir  = 1'b1;
        end else begin
          next_addr = rom_addr + 1'b1;
        end
      end else if (rom_addr == '0) begin
        next_addr = rom_addr + 1'b1;
        next_dir  = 1'b0;
      end else begin
        next_addr = rom_addr - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                dir_down <= 1'b0;
    else if (state == LOAD) dir_down <= next_dir;
  end
`else
  always_comb begin
    next_addr = (rom_addr == LAST) ? '0 : rom_addr + 1'b1;
  end
`endif

  // A step is IDLE -> FETCH -> WAIT -> LOAD; rom_q is captured at the end of
  // WAIT so the new pattern is visible three cycles after the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rom_addr    <= '0;
      rom_rd      <= 1'b0;
      pattern     <= '0;
      frame_start <= 1'b0;
    end else begin
      rom_rd      <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            state  <= FETCH;
            rom_rd <= 1'b1;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          pattern <= rom_q;
          state   <= LOAD;
        end
        LOAD: begin
          rom_addr    <= next_addr;
          frame_start <= (rom_addr == '0);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_player.sv
// Directed bench for pattern_player: a 4-word player and a 1-word player,
// each fed by a behavioural synchronous ROM.
`timescale 1ns/1ps
module tb_pattern_player;

  localparam int DW = 10;
  localparam int AW = 8;

`ifdef PATTERN_PLAYER_PINGPONG_EN
  localparam logic [7:0] A19 = 8'd2;
  localparam logic [9:0] P22 = 10'h004;
  localparam logic       F23 = 1'b0;
  localparam logic [7:0] SEQ [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1};
`else
  localparam logic [7:0] A19 = 8'd0;
  localparam logic [9:0] P22 = 10'h001;
  localparam logic       F23 = 1'b1;
  localparam logic [7:0] SEQ [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, run = 1'b0;
  logic [1:0]    speed = 2'd0;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [DW-1:0] rom_q = '0;
  logic [DW-1:0] pattern;
  logic          frame_start;

  logic          rst_b = 1'b1, run_b = 1'b0;
  logic [AW-1:0] rom_addr_b;
  logic          rom_rd_b;
  logic [DW-1:0] rom_q_b = '0;
  logic [DW-1:0] pattern_b;
  logic          frame_b;

  logic [DW-1:0] rom_a [4] = '{10'h001, 10'h002, 10'h004, 10'h008};

  pattern_player #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LENGTH(4), .TICK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .run(run), .speed(speed),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_q(rom_q),
    .pattern(pattern), .frame_start(frame_start)
  );

  pattern_player #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LENGTH(1), .TICK_DIV(4)) dut_b (
    .clk(clk), .rst(rst_b), .run(run_b), .speed(2'd0),
    .rom_addr(rom_addr_b), .rom_rd(rom_rd_b), .rom_q(rom_q_b),
    .pattern(pattern_b), .frame_start(frame_b)
  );

  always @(posedge clk) if (rom_rd) rom_q <= rom_a[rom_addr[1:0]];
  always @(posedge clk) if (rom_rd_b) rom_q_b <= 10'h2AA;

  int checks = 0;
  int failures = 0;
  int fcount = 0;

  typedef struct {
    logic [DW-1:0] pat;
    logic          rd;
    logic [AW-1:0] addr;
    logic          frame;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Steps until rom_rd is seen, counting frame_start pulses on the way.
  task automatic wait_rd(input string name, output int waited);
    waited = 0;
    do begin
      cyc();
      waited++;
      if (frame_start) fcount++;
    end while (!rom_rd && waited < 200);
    if (!rom_rd) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout after %0d cycles waiting for rom_rd", name, waited);
    end
  endtask

  task automatic reset_a(input logic [1:0] spd);
    rst = 1'b1;
    run = 1'b0;
    speed = spd;
    cyc();
    cyc();
    rst = 1'b0;
    run = 1'b1;
    fcount = 0;
  endtask

  initial begin
    int w, w2, rd_cnt, fr_cnt, nz, nchg;
    int chg [3];
    logic [DW-1:0] prev;

    vecs[0]  = '{10'h000, 1'b0, 8'd0, 1'b0};
    vecs[1]  = '{10'h000, 1'b0, 8'd0, 1'b0};
    vecs[2]  = '{10'h000, 1'b0, 8'd0, 1'b0};
    vecs[3]  = '{10'h000, 1'b1, 8'd0, 1'b0};
    vecs[4]  = '{10'h000, 1'b0, 8'd0, 1'b0};
    vecs[5]  = '{10'h001, 1'b0, 8'd0, 1'b0};
    vecs[6]  = '{10'h001, 1'b0, 8'd1, 1'b1};
    vecs[7]  = '{10'h001, 1'b1, 8'd1, 1'b0};
    vecs[8]  = '{10'h001, 1'b0, 8'd1, 1'b0};
    vecs[9]  = '{10'h002, 1'b0, 8'd1, 1'b0};
    vecs[10] = '{10'h002, 1'b0, 8'd2, 1'b0};
    vecs[11] = '{10'h002, 1'b1, 8'd2, 1'b0};
    vecs[12] = '{10'h002, 1'b0, 8'd2, 1'b0};
    vecs[13] = '{10'h004, 1'b0, 8'd2, 1'b0};
    vecs[14] = '{10'h004, 1'b0, 8'd3, 1'b0};
    vecs[15] = '{10'h004, 1'b1, 8'd3, 1'b0};
    vecs[16] = '{10'h004, 1'b0, 8'd3, 1'b0};
    vecs[17] = '{10'h008, 1'b0, 8'd3, 1'b0};
    vecs[18] = '{10'h008, 1'b0, A19,  1'b0};
    vecs[19] = '{10'h008, 1'b1, A19,  1'b0};
    vecs[20] = '{10'h008, 1'b0, A19,  1'b0};
    vecs[21] = '{P22,     1'b0, A19,  1'b0};
    vecs[22] = '{P22,     1'b0, 8'd1, F23};
    vecs[23] = '{P22,     1'b1, 8'd1, 1'b0};

    // Reset state, then the cycle-by-cycle table at speed 0.
    cyc();
    cyc();
    check("reset_pattern", pattern, 10'h000);
    check("reset_rom_addr", rom_addr, 8'd0);
    check("reset_rom_rd", rom_rd, 1'b0);
    check("reset_frame", frame_start, 1'b0);
    rst = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc();
      check($sformatf("tbl%0d_pattern", i + 1), pattern, vecs[i].pat);
      check($sformatf("tbl%0d_rom_rd", i + 1), rom_rd, vecs[i].rd);
      check($sformatf("tbl%0d_rom_addr", i + 1), rom_addr, vecs[i].addr);
      check($sformatf("tbl%0d_frame", i + 1), frame_start, vecs[i].frame);
    end

    // Eight fetch addresses and the frame pulses that go with them.
    reset_a(2'd0);
    for (int j = 0; j < 8; j++) begin
      wait_rd("seq_wait", w);
      check($sformatf("seq%0d_addr", j), rom_addr, SEQ[j]);
    end
    repeat (4) begin
      cyc();
      if (frame_start) fcount++;
    end
    check("seq_frame_count", fcount, 2);

    // speed=2: 16 cycles between pattern updates, one rom_rd cycle per step.
    reset_a(2'd2);
    wait_rd("slow_first", w);
    check("slow_first_wait", w, 16);
    rd_cnt = 0;
    nchg = 0;
    prev = pattern;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (rom_rd) rd_cnt++;
      if (pattern != prev && nchg < 3) begin
        chg[nchg] = c;
        nchg++;
      end
      prev = pattern;
    end
    check("slow_rd_count", rd_cnt, 2);
    check("slow_change_count", nchg, 3);
    check("slow_first_change", chg[0], 2);
    check("slow_update_gap", chg[1] - chg[0], 16);

    // Speed drop below the running count ticks on the next cycle.
    reset_a(2'd2);
    repeat (10) cyc();
    check("speed_chg_before", rom_rd, 1'b0);
    speed = 2'd0;
    cyc();
    check("speed_chg_tick", rom_rd, 1'b1);

    // run dropped while the fetch is in flight.
    reset_a(2'd0);
    wait_rd("stop_wait", w);
    cyc();
    run = 1'b0;
    cyc();
    check("stop_loaded", pattern, 10'h001);
    rd_cnt = 0;
    nchg = 0;
    repeat (50) begin
      cyc();
      if (rom_rd) rd_cnt++;
      if (pattern != 10'h001) nchg++;
    end
    check("stop_no_rd", rd_cnt, 0);
    check("stop_pattern_held", nchg, 0);
    check("stop_addr_held", rom_addr, 8'd1);

    // Reset asserted while in WAIT.
    reset_a(2'd0);
    wait_rd("rstw_first", w);
    wait_rd("rstw_second", w2);
    check("rstw_fetch_addr", rom_addr, 8'd1);
    cyc();
    check("rstw_pre_pattern", pattern, 10'h001);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rstw_pattern", pattern, 10'h000);
    check("rstw_rom_addr", rom_addr, 8'd0);
    check("rstw_rom_rd", rom_rd, 1'b0);
    check("rstw_frame", frame_start, 1'b0);
    cyc();
    check("rstw_not_applied", pattern, 10'h000);
    wait_rd("rstw_restart", w);
    check("rstw_restart_addr", rom_addr, 8'd0);
    cyc();
    cyc();
    check("rstw_restart_pattern", pattern, 10'h001);

    // LENGTH=1 player.
    cyc();
    rst_b = 1'b0;
    run_b = 1'b1;
    rd_cnt = 0;
    fr_cnt = 0;
    nz = 0;
    repeat (40) begin
      cyc();
      if (rom_rd_b) rd_cnt++;
      if (frame_b) fr_cnt++;
      if (rom_addr_b != '0) nz++;
    end
    check("len1_rd_count", rd_cnt, 10);
    check("len1_frame_count", fr_cnt, 9);
    check("len1_addr_nonzero", nz, 0);
    check("len1_pattern", pattern_b, 10'h2AA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
